// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, out-of-order completion, single in-order retire,
// and a one-cycle flush on an exception at head or an interrupt at a macro-op boundary.
module rob_ctrl #(
    parameter int ROB_ENTRIES = 16,
    parameter int NUM_PREGS   = 64,
    parameter int NUM_AREGS   = 32,
    localparam int IW = $clog2(ROB_ENTRIES),
    localparam int PW = $clog2(NUM_PREGS),
    localparam int AW = $clog2(NUM_AREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    input  logic [AW-1:0] alloc_areg,
    input  logic [PW-1:0] alloc_preg,
    input  logic [PW-1:0] alloc_old_preg,
    input  logic          alloc_mop_begin,
    input  logic          alloc_mop_end,
    output logic [IW-1:0] alloc_idx,
    input  logic          cpl_valid,
    input  logic [IW-1:0] cpl_idx,
    input  logic          cpl_exception,
    output logic          commit_valid,
    output logic [AW-1:0] commit_areg,
    output logic [PW-1:0] commit_preg,
    output logic          free_valid,
    output logic [PW-1:0] free_preg,
    input  logic          irq_req,
    output logic          irq_ack,
    output logic          flush_valid,
    output logic          flush_cause,
    output logic          empty
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [IW:0] CNT_FULL = ROB_ENTRIES[IW:0];

    state_t                        state_q, state_d;
    logic                          cause_q, cause_d;
    logic [IW-1:0]                 head_q, head_d, tail_q, tail_d;
    logic [IW:0]                   count_q, count_d;
    logic                          at_bnd_q, at_bnd_d;
    logic [ROB_ENTRIES-1:0]        valid_q, valid_d, busy_q, busy_d, exc_q, exc_d;
    logic [ROB_ENTRIES-1:0]        mop_begin_q, mop_end_q;
    logic [ROB_ENTRIES-1:0][AW-1:0] areg_q;
    logic [ROB_ENTRIES-1:0][PW-1:0] preg_q, old_q;

    logic run, hr, take_exc, take_irq, do_alloc;

    assign run      = (state_q == RUN);
    assign hr       = valid_q[head_q] && !busy_q[head_q];
    assign take_exc = run && hr && exc_q[head_q];
    assign take_irq = run && irq_req && at_bnd_q && !take_exc;

    // A same-cycle retire never makes room for this cycle's allocation.
    assign alloc_ready  = run && (count_q != CNT_FULL) && !take_exc && !take_irq;
    assign do_alloc     = alloc_valid && alloc_ready;
    assign alloc_idx    = tail_q;

    assign commit_valid = run && hr && !exc_q[head_q] && !take_irq;
    assign free_valid   = commit_valid;
    assign commit_areg  = commit_valid ? areg_q[head_q] : '0;
    assign commit_preg  = commit_valid ? preg_q[head_q] : '0;
    assign free_preg    = commit_valid ? old_q[head_q]  : '0;

    assign flush_valid  = (state_q == FLUSH);
    assign flush_cause  = flush_valid && cause_q;
    assign irq_ack      = flush_valid && cause_q;
    assign empty        = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        at_bnd_d = at_bnd_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        exc_d    = exc_q;
        if (state_q == FLUSH) begin
            state_d  = RUN;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            at_bnd_d = 1'b1;
            valid_d  = '0;
        end else begin
            if (take_exc || take_irq) begin
                state_d = FLUSH;
                cause_d = take_irq;
            end
            if (cpl_valid && valid_q[cpl_idx]) begin
                busy_d[cpl_idx] = 1'b0;
                exc_d[cpl_idx]  = cpl_exception;
            end
            if (commit_valid) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + IW'(1);
                at_bnd_d        = mop_end_q[head_q];
            end
            if (do_alloc) begin
                valid_d[tail_q] = 1'b1;
                busy_d[tail_q]  = 1'b1;
                exc_d[tail_q]   = 1'b0;
                tail_d          = tail_q + IW'(1);
            end
            count_d = count_q + (IW+1)'(do_alloc) - (IW+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cause_q  <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            at_bnd_q <= 1'b1;
            valid_q  <= '0;
            busy_q   <= '0;
            exc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            at_bnd_q <= at_bnd_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            exc_q    <= exc_d;
        end
    end

    // Payload is only meaningful while valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            areg_q[tail_q]      <= alloc_areg;
            preg_q[tail_q]      <= alloc_preg;
            old_q[tail_q]       <= alloc_old_preg;
            mop_begin_q[tail_q] <= alloc_mop_begin;
            mop_end_q[tail_q]   <= alloc_mop_end;
        end
    end

    // The first micro-op of a macro-op can only retire right after a macro-op boundary.
    a_mop_begin_at_boundary: assert property (@(posedge clk) disable iff (!rst_n)
        commit_valid && mop_begin_q[head_q] |-> at_bnd_q);

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl: per-cycle vector table with expected outputs, plus a commit scoreboard
// fed from accepted allocations and drained by expected retires.
module tb_rob_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid, alloc_ready, alloc_mop_begin, alloc_mop_end;
    logic [4:0] alloc_areg, commit_areg;
    logic [5:0] alloc_preg, alloc_old_preg, commit_preg, free_preg;
    logic [3:0] alloc_idx, cpl_idx;
    logic       cpl_valid, cpl_exception, commit_valid, free_valid;
    logic       irq_req, irq_ack, flush_valid, flush_cause, empty;

    always #5 clk = ~clk;

    rob_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_areg(alloc_areg),
        .alloc_preg(alloc_preg), .alloc_old_preg(alloc_old_preg),
        .alloc_mop_begin(alloc_mop_begin), .alloc_mop_end(alloc_mop_end), .alloc_idx(alloc_idx),
        .cpl_valid(cpl_valid), .cpl_idx(cpl_idx), .cpl_exception(cpl_exception),
        .commit_valid(commit_valid), .commit_areg(commit_areg), .commit_preg(commit_preg),
        .free_valid(free_valid), .free_preg(free_preg),
        .irq_req(irq_req), .irq_ack(irq_ack), .flush_valid(flush_valid),
        .flush_cause(flush_cause), .empty(empty)
    );

    typedef struct {
        logic       rst, av;
        logic [4:0] aa;
        logic [5:0] ap, ao;
        logic       mb, me, cv;
        logic [3:0] ci;
        logic       ce, irq;
        logic       er;
        logic [3:0] ei;
        logic       ecv;
        logic [5:0] ecp, efp;
        logic       efl, efc, eia, eem;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [5:0] p, o;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t V(int rst, int av, int aa, int ap, int ao, int mb, int me,
                               int cv, int ci, int ce, int irq,
                               int er, int ei, int ecv, int ecp, int efp,
                               int efl, int efc, int eia, int eem);
        vec_t v;
        v.rst = rst[0]; v.av = av[0]; v.aa = aa[4:0]; v.ap = ap[5:0]; v.ao = ao[5:0];
        v.mb = mb[0]; v.me = me[0]; v.cv = cv[0]; v.ci = ci[3:0]; v.ce = ce[0]; v.irq = irq[0];
        v.er = er[0]; v.ei = ei[3:0]; v.ecv = ecv[0]; v.ecp = ecp[5:0]; v.efp = efp[5:0];
        v.efl = efl[0]; v.efc = efc[0]; v.eia = eia[0]; v.eem = eem[0];
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL row%0d %s: got %0d expected %0d", row, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int row);
        sb_t e;
        rst_n = !v.rst;
        alloc_valid = v.av; alloc_areg = v.aa; alloc_preg = v.ap; alloc_old_preg = v.ao;
        alloc_mop_begin = v.mb; alloc_mop_end = v.me;
        cpl_valid = v.cv; cpl_idx = v.ci; cpl_exception = v.ce; irq_req = v.irq;
        @(negedge clk);
        chk("alloc_ready",  row, int'(alloc_ready),  int'(v.er));
        chk("alloc_idx",    row, int'(alloc_idx),    int'(v.ei));
        chk("commit_valid", row, int'(commit_valid), int'(v.ecv));
        chk("free_valid",   row, int'(free_valid),   int'(v.ecv));
        chk("commit_preg",  row, int'(commit_preg),  int'(v.ecp));
        chk("free_preg",    row, int'(free_preg),    int'(v.efp));
        chk("flush_valid",  row, int'(flush_valid),  int'(v.efl));
        chk("flush_cause",  row, int'(flush_cause),  int'(v.efc));
        chk("irq_ack",      row, int'(irq_ack),      int'(v.eia));
        chk("empty",        row, int'(empty),        int'(v.eem));
        if (v.ecv) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL row%0d sb_underflow: got commit expected no pending entry", row);
            end else begin
                e = sbq.pop_front();
                chk("sb_commit_areg", row, int'(commit_areg), int'(e.a));
                chk("sb_commit_preg", row, int'(commit_preg), int'(e.p));
                chk("sb_free_preg",   row, int'(free_preg),   int'(e.o));
            end
        end else begin
            chk("commit_areg_idle", row, int'(commit_areg), 0);
        end
        if (v.av && v.er) begin
            e.a = v.aa; e.p = v.ap; e.o = v.ao;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.efl || v.rst) sbq.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 0; alloc_areg = '0; alloc_preg = '0; alloc_old_preg = '0;
        alloc_mop_begin = 0; alloc_mop_end = 0;
        cpl_valid = 0; cpl_idx = '0; cpl_exception = 0; irq_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty",        -1, int'(empty),        1);
        chk("rst_alloc_ready",  -1, int'(alloc_ready),  1);
        chk("rst_alloc_idx",    -1, int'(alloc_idx),    0);
        chk("rst_commit_valid", -1, int'(commit_valid), 0);
        chk("rst_free_valid",   -1, int'(free_valid),   0);
        chk("rst_flush_valid",  -1, int'(flush_valid),  0);
        chk("rst_flush_cause",  -1, int'(flush_cause),  0);
        chk("rst_irq_ack",      -1, int'(irq_ack),      0);
        chk("rst_commit_preg",  -1, int'(commit_preg),  0);
        chk("rst_free_preg",    -1, int'(free_preg),    0);
        @(posedge clk);
        #1;

        //            rst av aa ap  ao mb me cv ci ce irq | er ei cv cp fp fl fc ia em
        // In-order retire of out-of-order completions
        tbl.push_back(V(0,1, 1,33, 1,1,1, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,1, 2,34, 2,1,1, 0,0,0,0,  1,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1, 3,35, 3,1,1, 0,0,0,0,  1,2,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,2,0,0,  1,3,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,0,0,0,  1,3,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,1,0,0,  1,3,1,33,1,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,3,1,34,2,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,3,1,35,3,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,3,0, 0,0,0,0,0,1));
        tbl.push_back(V(1,0, 0, 0, 0,0,0, 0,0,0,0,  1,3,0, 0,0,0,0,0,1));
        // Exception on idx 1
        tbl.push_back(V(0,1, 4,40, 4,1,1, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,1, 5,41, 5,0,1, 0,0,0,0,  1,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1, 6,42, 6,1,1, 0,0,0,0,  1,2,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1, 7,43, 7,1,1, 0,0,0,0,  1,3,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,0,0,0,  1,4,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,1,1,0,  1,4,1,40,4,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,2,0,0,  0,4,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,3,0,0,  0,4,0, 0,0,1,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        // Interrupt waits for the macro-op boundary
        tbl.push_back(V(0,1, 8,48, 8,1,0, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,1, 9,49, 9,0,0, 0,0,0,0,  1,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1,10,50,10,0,1, 0,0,0,0,  1,2,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,1,11,51,11,1,1, 0,0,0,0,  1,3,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,0,0,0,  1,4,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,1,0,0,  1,4,1,48,8,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,2,0,1,  1,4,1,49,9,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,3,0,1,  1,4,1,50,10,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,1,  0,4,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,1,  0,4,0, 0,0,1,1,1,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        // Exception and interrupt together: exception wins, interrupt follows
        tbl.push_back(V(0,1,12,52,12,1,1, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,1,13,53,13,1,1, 0,0,0,0,  1,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,0,1,0,  1,2,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,1,0,1,  0,2,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,1,  0,2,0, 0,0,1,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,1,  0,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  0,0,0, 0,0,1,1,1,1));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        // Reset during the flush cycle
        tbl.push_back(V(0,1,14,54,14,1,1, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 1,0,1,0,  1,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  0,1,0, 0,0,0,0,0,0));
        tbl.push_back(V(1,0, 0, 0, 0,0,0, 0,0,0,0,  0,1,0, 0,0,1,0,0,0));
        tbl.push_back(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  1,0,0, 0,0,0,0,0,1));

        foreach (tbl[i]) apply(tbl[i], i + 1);

        // Fill to capacity, then retire one and check the freed slot only opens a cycle later
        for (int i = 0; i < 16; i++)
            apply(V(0,1,i,16+i,i,1,1, 0,0,0,0, 1,i,0,0,0,0,0,0,(i == 0) ? 1 : 0), 100 + i);
        apply(V(0,1,20,20,20,1,1, 0,0,0,0,  0,0,0, 0,0,0,0,0,0), 116);
        apply(V(0,1,20,20,20,1,1, 1,0,0,0,  0,0,0, 0,0,0,0,0,0), 117);
        apply(V(0,1,20,20,20,1,1, 0,0,0,0,  0,0,1,16,0,0,0,0,0), 118);
        apply(V(0,1,21,21,21,1,1, 0,0,0,0,  1,0,0, 0,0,0,0,0,0), 119);
        apply(V(0,0, 0, 0, 0,0,0, 0,0,0,0,  0,1,0, 0,0,0,0,0,0), 120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Reorder-buffer controller between rename/issue and commit.
- Allocates ROB entries in program order at issue and marks them done on execution completion.
- Retires at most one entry per cycle in order: drives the commit register allocation table update and the physical-register free.
- Handles exceptions and macro-op-boundary interrupts by flushing the ROB; rename recovers its mapping from the commit RAT.

Parameters:
- ROB_ENTRIES, 16, number of entries; power of two, at least 2.
- NUM_PREGS, 64, physical registers; PW = $clog2(NUM_PREGS).
- NUM_AREGS, 32, architectural registers; AW = $clog2(NUM_AREGS).
- IW = $clog2(ROB_ENTRIES), derived; not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- alloc_valid  in  1  issue requests an entry.
- alloc_ready  out  1  entry available.
- alloc_areg  in  AW  destination architectural register.
- alloc_preg  in  PW  newly mapped physical register.
- alloc_old_preg  in  PW  previous physical mapping of alloc_areg.
- alloc_mop_begin  in  1  first micro-op of a macro-instruction.
- alloc_mop_end  in  1  last micro-op of a macro-instruction.
- alloc_idx  out  IW  index given to this allocation (= tail).
- cpl_valid  in  1  execution completion.
- cpl_idx  in  IW  completing entry.
- cpl_exception  in  1  completing entry faulted.
- commit_valid  out  1  head entry retires this cycle.
- commit_areg  out  AW  commit RAT write address.
- commit_preg  out  PW  commit RAT write data.
- free_valid  out  1  release free_preg to the free list.
- free_preg  out  PW  old_preg of the retiring entry.
- irq_req  in  1  level interrupt request.
- irq_ack  out  1  interrupt taken (pulse).
- flush_valid  out  1  pipeline flush (pulse).
- flush_cause  out  1  0 = exception, 1 = interrupt.
- empty  out  1  count == 0.

Behaviour:
- Storage per entry: valid, busy, exception, areg, preg, old_preg, mop_begin, mop_end.
- Pointers: head, tail (IW bits, wrap modulo ROB_ENTRIES), count (IW+1 bits), at_boundary flag, state in {RUN, FLUSH}.
- Reset (rst_n low at a clk edge):
  - All valid bits cleared; head = tail = count = 0; at_boundary = 1; state = RUN.
  - Every output is 0 except empty = 1 and alloc_ready = 1 once reset is released.
  - Reset takes priority over any in-progress flush.
- Allocation:
  - alloc_ready = (state == RUN) && (count < ROB_ENTRIES) && !take_exc && !take_irq.
  - On alloc_valid && alloc_ready, at the clock edge: entry[tail] gets valid = 1, busy = 1, exception = 0 and the payload fields; tail increments.
  - alloc_idx = tail combinationally.
  - A same-cycle commit does not free space for that cycle's allocation: full means alloc_ready = 0.
- Completion:
  - cpl_valid to a valid entry sets busy = 0 and exception = cpl_exception at the edge.
  - Completion to an invalid entry is ignored.
  - A completing head entry becomes retireable in the next cycle; there is no bypass.
- Head status: hr = valid[head] && !busy[head].
  - take_exc = RUN && hr && exception[head].
  - take_irq = RUN && irq_req && at_boundary && !take_exc.
- Commit:
  - commit_valid = RUN && hr && !exception[head] && !take_irq.
  - commit_valid is combinational and asserts together with free_valid; commit_areg/commit_preg/free_preg come from entry[head].
  - When not committing, commit_areg/commit_preg/free_preg are 0.
  - On commit: valid[head] = 0, head increments, at_boundary = mop_end[head].
  - Count: alloc + commit in the same cycle leaves count unchanged; wrap to index 0 after ROB_ENTRIES-1.
- Flush:
  - Exception has priority over interrupt.
  - On take_exc or take_irq, next state = FLUSH; the cause is registered.
  - In FLUSH for exactly one cycle: flush_valid = 1, flush_cause = registered cause, irq_ack = cause.
  - In FLUSH: alloc_ready = 0, commit_valid = 0; completions are ignored.
  - At the end of FLUSH: all valid bits cleared, head = tail = count = 0, at_boundary = 1, state = RUN.
  - The faulting entry is neither committed nor freed.
- Latency: allocation to retire is at least 2 cycles (allocate, complete, retire in the cycle after completion).

Test Plan:
- Reset, then allocate 3 entries (areg 1/2/3, preg 33/34/35, old 1/2/3); complete idx 2, 0, 1 -> commits occur in order idx 0, 1, 2 with commit_preg 33, 34, 35 and free_preg 1, 2, 3; empty = 1 afterward.
- Allocate 16 with no completion -> alloc_ready = 0 after the 16th and tail wraps to 0. Complete idx 0 and allocate in the retire cycle -> no allocation; the next cycle allocates with alloc_idx = 0.
- Allocate 4, complete idx 1 with cpl_exception = 1 and the rest normally -> idx 0 commits. The next cycle has no commit. flush_valid = 1, flush_cause = 0 for one cycle. Then empty = 1, head = tail = 0, and no free of idx 1.
- Macro-op begin/-/end micro-ops all completed; assert irq_req after the first commit -> the second and third commit, then the fourth entry is not committed. flush_valid = 1, flush_cause = 1, irq_ack = 1 for one cycle.
- Exception at head and irq_req in the same cycle -> flush_cause = 0 and irq_ack = 0; the interrupt is taken on a later boundary.
- rst_n low during the FLUSH cycle -> flush_valid = 0 the next cycle and all state at reset values.
